piso_serializer: RTL and testbench

Parallel-in serial-out converter that sits at the output end of the PIPO register path: accepts one WIDTH-bit word per valid/ready handshake and emits it one bit per accepted shift beat on a single serial line. Provides a last-bit marker and supports back-to-back words with no idle gap. Feeds the serial link whose receiving end is the SIPO/PIPO capture side.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_serializer_bit_counter.sv | 34 +++
 rtl/piso_serializer.sv | 92 +++++++++
 tb/tb_piso_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer and its bit counter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter width for a modulus-w counter, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulus counter with synchronous active-low clear, enable and terminal count.
module bit_counter
   import piso_pkg::*;
#(
   parameter int unsigned MODULUS = 8,
   parameter int unsigned CW      = cnt_width(MODULUS)
) (
   input  logic clk_i,
   input  logic clr_n_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tc_o = (count_q == CW'(MODULUS - 1));

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = tc_o ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with valid/ready load, shift enable,
// last-bit marker and gapless back-to-back words.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             last,
   output logic             busy
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic             beat;
   logic             accept;
   logic             tc;

   assign beat   = (state_q == SHIFT) && shift_en;
   assign accept = load_ready && load_valid;
   assign last   = tc && (state_q == SHIFT);

   // Clearing on accept restarts the count even when a new word follows the last beat.
   bit_counter #(
      .MODULUS (WIDTH)
   ) u_bit_counter (
      .clk_i   (clk),
      .clr_n_i (reset && !accept),
      .en_i    (beat),
      .tc_o    (tc)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = SHIFT;
         SHIFT: if (beat && last && !load_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_ready   = 1'b0;
      serial_valid = 1'b0;
      busy         = 1'b0;
      serial_out   = 1'b0;
      if (reset) begin
         load_ready = (state_q == IDLE) || (beat && last);
      end
      if (state_q == SHIFT) begin
         serial_valid = 1'b1;
         busy         = 1'b1;
         serial_out   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
      end
   end

   always_comb begin
      shreg_d = shreg_q;
      if (accept) begin
         shreg_d = D;
      end else if (beat) begin
         shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: LSB-first and MSB-first instances driven with identical stimulus.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] D;
   logic       load_valid;
   logic       shift_en;

   logic rdy_l, sout_l, sval_l, last_l, busy_l;
   logic rdy_m, sout_m, sval_m, last_m, busy_m;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .reset(reset), .D(D), .load_valid(load_valid), .load_ready(rdy_l),
      .shift_en(shift_en), .serial_out(sout_l), .serial_valid(sval_l), .last(last_l), .busy(busy_l)
   );

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .reset(reset), .D(D), .load_valid(load_valid), .load_ready(rdy_m),
      .shift_en(shift_en), .serial_out(sout_m), .serial_valid(sval_m), .last(last_m), .busy(busy_m)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_val_l"},  32'(sval_l), 32'd0);
      chk({tag, "_val_m"},  32'(sval_m), 32'd0);
      chk({tag, "_busy_l"}, 32'(busy_l), 32'd0);
      chk({tag, "_busy_m"}, 32'(busy_m), 32'd0);
      chk({tag, "_last_l"}, 32'(last_l), 32'd0);
      chk({tag, "_last_m"}, 32'(last_m), 32'd0);
      chk({tag, "_sout_l"}, 32'(sout_l), 32'd0);
      chk({tag, "_sout_m"}, 32'(sout_m), 32'd0);
   endtask

   task automatic chk_bit(input string tag, input logic el, input logic em, input logic elast);
      chk({tag, "_sout_l"}, 32'(sout_l), 32'(el));
      chk({tag, "_sout_m"}, 32'(sout_m), 32'(em));
      chk({tag, "_val_l"},  32'(sval_l), 32'd1);
      chk({tag, "_val_m"},  32'(sval_m), 32'd1);
      chk({tag, "_last_l"}, 32'(last_l), 32'(elast));
      chk({tag, "_last_m"}, 32'(last_m), 32'(elast));
   endtask

   task automatic load_word(input logic [7:0] d);
      @(negedge clk);
      D = d; load_valid = 1'b1; shift_en = 1'b0;
      #1;
      chk("ld_rdy_l", 32'(rdy_l), 32'd1);
      chk("ld_rdy_m", 32'(rdy_m), 32'd1);
      @(negedge clk);
      load_valid = 1'b0; D = '0;
   endtask

   // el/em: expected emitted bit i at index i for LSB-first / MSB-first instance.
   task automatic send_word(input logic [7:0] d, input logic [7:0] el, input logic [7:0] em,
                            input int stall_at, input int stall_len);
      int busy_cyc;
      busy_cyc = 0;
      load_word(d);
      for (int i = 0; i < 8; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               shift_en = 1'b0;
               #1;
               chk_bit("stall", el[i], em[i], i == 7);
               chk("stall_rdy", 32'(rdy_l), 32'd0);
               busy_cyc += int'(busy_l);
               @(negedge clk);
            end
         end
         shift_en = 1'b1;
         #1;
         chk_bit("bit", el[i], em[i], i == 7);
         busy_cyc += int'(busy_l);
         @(negedge clk);
      end
      shift_en = 1'b0;
      #1;
      chk_idle("after");
      chk("after_rdy", 32'(rdy_l), 32'd1);
      chk("busy_cycles", 32'(busy_cyc), 32'(8 + ((stall_at >= 0) ? stall_len : 0)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] b2b_l;
      logic [15:0] b2b_m;
      b2b_l = 16'h8001;
      b2b_m = 16'h0180;
      reset = 1'b0; D = '0; load_valid = 1'b0; shift_en = 1'b0;

      // Reset held for three edges
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk_idle("rst");
         chk("rst_rdy_l", 32'(rdy_l), 32'd0);
         chk("rst_rdy_m", 32'(rdy_m), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("rel_rdy_l", 32'(rdy_l), 32'd1);
      chk("rel_rdy_m", 32'(rdy_m), 32'd1);
      chk_idle("rel");

      // Single word, both bit orders give 1,0,1,0,0,1,0,1
      send_word(8'hA5, 8'hA5, 8'hA5, -1, 0);

      // Stall of 3 cycles before bit 3
      send_word(8'h0F, 8'h0F, 8'hF0, 3, 3);

      // Back-to-back 8'h01 then 8'h80
      load_word(8'h01);
      for (int i = 0; i < 16; i++) begin
         shift_en = 1'b1;
         if (i == 7) begin
            D = 8'h80; load_valid = 1'b1;
         end
         #1;
         chk_bit("b2b", b2b_l[i], b2b_m[i], (i == 7) || (i == 15));
         if (i == 7) begin
            chk("b2b_rdy_l", 32'(rdy_l), 32'd1);
            chk("b2b_rdy_m", 32'(rdy_m), 32'd1);
         end
         @(negedge clk);
         load_valid = 1'b0; D = '0;
      end
      shift_en = 1'b0;
      #1;
      chk_idle("b2b_end");

      // Reset mid-word after four bits of 8'hFF
      load_word(8'hFF);
      for (int i = 0; i < 4; i++) begin
         shift_en = 1'b1;
         #1;
         chk_bit("ff", 1'b1, 1'b1, 1'b0);
         @(negedge clk);
      end
      reset = 1'b0;
      #1;
      chk("midrst_rdy_l", 32'(rdy_l), 32'd0);
      chk("midrst_rdy_m", 32'(rdy_m), 32'd0);
      @(negedge clk);
      #1;
      chk_idle("midrst");
      reset = 1'b1; shift_en = 1'b0;

      send_word(8'h3C, 8'h3C, 8'h3C, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
